// File: rtl/pe_dbuf_mac.sv
// Weight-stationary systolic PE: int MAC with a double-buffered (shadow/active) weight.
// Optional SAT_EN macro: clamp the psum on overflow and add a sticky sat_flag output.
module pe_dbuf_mac #(
  parameter int DATA_IN_BW     = 8,
  parameter int WEIGHT_BW      = 8,
  parameter int PARTIAL_SUM_BW = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_mode,
  input  logic [DATA_IN_BW-1:0]     DIN,
  input  logic                      din_valid,
  input  logic [PARTIAL_SUM_BW-1:0] PSUM_IN,
  input  logic [WEIGHT_BW-1:0]      W_IN,
  input  logic                      w_shift_in,
  input  logic                      swap_in,
  output logic [DATA_IN_BW-1:0]     DF_COL,
  output logic                      df_valid,
  output logic [PARTIAL_SUM_BW-1:0] PSUM_OUT,
  output logic                      psum_valid,
  output logic [WEIGHT_BW-1:0]      W_OUT,
  output logic                      w_shift_out,
  output logic                      swap_out,
`ifdef SAT_EN
  output logic                      sat_flag,
`endif
  output logic                      shadow_full
);

  localparam int P = PARTIAL_SUM_BW;
  localparam int S = P + 1;

  logic [WEIGHT_BW-1:0] active_w;
  logic [WEIGHT_BW-1:0] shadow;
  logic [S-1:0]         din_x;
  logic [S-1:0]         w_x;
  logic [S-1:0]         psum_x;
  logic [S-1:0]         prod;
  logic [S-1:0]         sum;
  logic [P-1:0]         res;
`ifdef SAT_EN
  logic                 sat_hit;
`endif

  // Operands extended to P+1 bits so the add cannot lose its carry/sign.
  always_comb begin
    din_x  = signed_mode
      ? {{(S-DATA_IN_BW){DIN[DATA_IN_BW-1]}}, DIN}
      : {{(S-DATA_IN_BW){1'b0}}, DIN};
    w_x    = signed_mode
      ? {{(S-WEIGHT_BW){active_w[WEIGHT_BW-1]}}, active_w}
      : {{(S-WEIGHT_BW){1'b0}}, active_w};
    psum_x = signed_mode
      ? {PSUM_IN[P-1], PSUM_IN}
      : {1'b0, PSUM_IN};
    prod   = din_x * w_x;
    sum    = psum_x + prod;
  end

  always_comb begin
    res = sum[P-1:0];
`ifdef SAT_EN
    sat_hit = 1'b0;
    if (signed_mode) begin
      if (sum[P] != sum[P-1]) begin
        sat_hit = 1'b1;
        res = sum[P] ? {1'b1, {(P-1){1'b0}}}
                     : {1'b0, {(P-1){1'b1}}};
      end
    end else if (sum[P]) begin
      sat_hit = 1'b1;
      res = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DF_COL      <= '0;
      df_valid    <= 1'b0;
      PSUM_OUT    <= '0;
      psum_valid  <= 1'b0;
      w_shift_out <= 1'b0;
      swap_out    <= 1'b0;
      active_w    <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
`ifdef SAT_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      df_valid    <= din_valid;
      psum_valid  <= din_valid;
      w_shift_out <= w_shift_in;
      swap_out    <= swap_in;
      if (din_valid) begin
        DF_COL   <= DIN;
        PSUM_OUT <= res;
`ifdef SAT_EN
        if (sat_hit) sat_flag <= 1'b1;
`endif
      end
      // A shift in the swap cycle refills the shadow, so it stays full.
      if (swap_in && shadow_full) begin
        active_w    <= shadow;
        shadow_full <= w_shift_in;
      end else if (w_shift_in) begin
        shadow_full <= 1'b1;
      end
      if (w_shift_in) shadow <= W_IN;
    end
  end

  assign W_OUT = shadow;

endmodule

// File: tb/tb_pe_dbuf_mac.sv
// Scoreboard bench for pe_dbuf_mac; expected psums queued at issue, checked at output.
// Build with SAT_EN defined to exercise the saturating variant.
module tb_pe_dbuf_mac;

  localparam int D = 8;
  localparam int W = 8;
  localparam int P = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic         signed_mode;
  logic [D-1:0] DIN;
  logic         din_valid;
  logic [P-1:0] PSUM_IN;
  logic [W-1:0] W_IN;
  logic         w_shift_in;
  logic         swap_in;
  logic [D-1:0] DF_COL;
  logic         df_valid;
  logic [P-1:0] PSUM_OUT;
  logic         psum_valid;
  logic [W-1:0] W_OUT;
  logic         w_shift_out;
  logic         swap_out;
  logic         shadow_full;
`ifdef SAT_EN
  logic         sat_flag;
`endif

  int total = 0;
  int bad   = 0;
  logic [P-1:0] q[$];
  logic [P-1:0] exp_v;
  logic [P-1:0] last_psum;
  logic [D-1:0] last_din;
  logic [W-1:0] mw;

  pe_dbuf_mac #(.DATA_IN_BW(D), .WEIGHT_BW(W), .PARTIAL_SUM_BW(P)) dut (
    .clk(clk), .rst(rst), .signed_mode(signed_mode),
    .DIN(DIN), .din_valid(din_valid), .PSUM_IN(PSUM_IN),
    .W_IN(W_IN), .w_shift_in(w_shift_in), .swap_in(swap_in),
    .DF_COL(DF_COL), .df_valid(df_valid),
    .PSUM_OUT(PSUM_OUT), .psum_valid(psum_valid),
    .W_OUT(W_OUT), .w_shift_out(w_shift_out),
    .swap_out(swap_out),
`ifdef SAT_EN
    .sat_flag(sat_flag),
`endif
    .shadow_full(shadow_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [P-1:0] model(
    input logic [D-1:0] din, input logic [W-1:0] w,
    input logic [P-1:0] ps, input logic sgn);
    longint a, b, p, s;
    logic [63:0] t;
    a = sgn ? longint'($signed(din)) : longint'(din);
    b = sgn ? longint'($signed(w))   : longint'(w);
    p = sgn ? longint'($signed(ps))  : longint'(ps);
    s = p + a * b;
`ifdef SAT_EN
    if (sgn) begin
      if (s > (longint'(1) << (P-1)) - 1) s = (longint'(1) << (P-1)) - 1;
      if (s < -(longint'(1) << (P-1)))    s = -(longint'(1) << (P-1));
    end else if (s > (longint'(1) << P) - 1) begin
      s = (longint'(1) << P) - 1;
    end
`endif
    t = 64'(s);
    return t[P-1:0];
  endfunction

  task automatic idle();
    din_valid = 0; w_shift_in = 0; swap_in = 0;
  endtask

  task automatic load_w(input logic [W-1:0] w);
    idle();
    W_IN = w; w_shift_in = 1; step();
    w_shift_in = 0; swap_in = 1; step();
    swap_in = 0;
    mw = w;
  endtask

  task automatic test_reset();
    rst = 1; signed_mode = 1; DIN = 0; PSUM_IN = 0; W_IN = 0;
    idle();
    step(); step();
    rst = 0;
    total++;
    if ({DF_COL, df_valid, PSUM_OUT, psum_valid, W_OUT,
         w_shift_out, swap_out, shadow_full} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got DF=%h PS=%h WO=%h full=%b",
               DF_COL, PSUM_OUT, W_OUT, shadow_full);
    end
`ifdef SAT_EN
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_sat got %b want 0", sat_flag);
    end
`endif
  endtask

  task automatic test_basic_mac();
    idle();
    W_IN = 8'hFD; w_shift_in = 1; step();
    total++;
    if (W_OUT !== 8'hFD || shadow_full !== 1 || w_shift_out !== 1) begin
      bad++;
      $display("FAIL shift got W_OUT=%h full=%b wso=%b want fd 1 1",
               W_OUT, shadow_full, w_shift_out);
    end
    w_shift_in = 0; swap_in = 1; step();
    total++;
    if (shadow_full !== 0 || swap_out !== 1) begin
      bad++;
      $display("FAIL swap got full=%b swap_out=%b want 0 1",
               shadow_full, swap_out);
    end
    swap_in = 0; din_valid = 1; DIN = 5; PSUM_IN = 100;
    q.push_back(19'd85);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v || psum_valid !== 1 || DF_COL !== 8'd5 || df_valid !== 1) begin
      bad++;
      $display("FAIL mac1 got %0d v=%b df=%0d want %0d", PSUM_OUT, psum_valid, DF_COL, exp_v);
    end
  endtask

  task automatic test_swap_with_mac();
    idle();
    W_IN = 8'd7; w_shift_in = 1; step();
    w_shift_in = 0; swap_in = 1; din_valid = 1; DIN = 2; PSUM_IN = 0;
    q.push_back(-19'sd6);
    step();
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v || psum_valid !== 1) begin
      bad++;
      $display("FAIL swap_old_w got %h want %h", PSUM_OUT, exp_v);
    end
    swap_in = 0; DIN = 2; PSUM_IN = 0;
    q.push_back(19'd14);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v || shadow_full !== 0) begin
      bad++;
      $display("FAIL swap_new_w got %0d full=%b want %0d 0", PSUM_OUT, shadow_full, exp_v);
    end
  endtask

  task automatic test_empty_swap();
    idle();
    swap_in = 1; step();
    swap_in = 0;
    total++;
    if (swap_out !== 1 || shadow_full !== 0 || psum_valid !== 0) begin
      bad++;
      $display("FAIL empty_swap got so=%b full=%b want 1 0", swap_out, shadow_full);
    end
    step();
    total++;
    if (swap_out !== 0) begin
      bad++;
      $display("FAIL swap_out_drop got %b want 0", swap_out);
    end
    din_valid = 1; DIN = 3; PSUM_IN = 1;
    q.push_back(19'd22);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v) begin
      bad++;
      $display("FAIL empty_swap_w got %0d want %0d", PSUM_OUT, exp_v);
    end
  endtask

  task automatic test_shift_swap();
    idle();
    W_IN = 8'd4; w_shift_in = 1; step();
    W_IN = 8'd9; swap_in = 1; step();
    w_shift_in = 0; swap_in = 0;
    total++;
    if (W_OUT !== 8'd9 || shadow_full !== 1) begin
      bad++;
      $display("FAIL shift_swap got W_OUT=%0d full=%b want 9 1", W_OUT, shadow_full);
    end
    din_valid = 1; DIN = 1; PSUM_IN = 0;
    q.push_back(19'd4);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v) begin
      bad++;
      $display("FAIL shift_swap_active got %0d want %0d", PSUM_OUT, exp_v);
    end
    W_IN = 8'd2; w_shift_in = 1; step();
    w_shift_in = 0; swap_in = 1; step();
    swap_in = 0; din_valid = 1; DIN = 3; PSUM_IN = 0;
    q.push_back(19'd6);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v || shadow_full !== 0) begin
      bad++;
      $display("FAIL overwrite got %0d full=%b want %0d 0", PSUM_OUT, shadow_full, exp_v);
    end
  endtask

  task automatic test_range();
    signed_mode = 0;
    load_w(8'hFF);
    din_valid = 1; DIN = 8'hFF; PSUM_IN = 0;
    q.push_back(19'd65025);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v) begin
      bad++;
      $display("FAIL unsigned_max got %0d want %0d", PSUM_OUT, exp_v);
    end
    signed_mode = 1;
    load_w(8'd1);
    din_valid = 1; DIN = 1; PSUM_IN = 19'd262143;
`ifdef SAT_EN
    q.push_back(19'h3FFFF);
`else
    q.push_back(19'h40000);
`endif
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v) begin
      bad++;
      $display("FAIL overflow got %h want %h", PSUM_OUT, exp_v);
    end
`ifdef SAT_EN
    total++;
    if (sat_flag !== 1) begin
      bad++;
      $display("FAIL sat_flag got %b want 1", sat_flag);
    end
    step();
    total++;
    if (sat_flag !== 1) begin
      bad++;
      $display("FAIL sat_sticky got %b want 1", sat_flag);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int m = 0; m < 2; m++) begin
      signed_mode = m[0];
      load_w(W'($urandom));
      for (int i = 0; i < 12; i++) begin
        din_valid = 1;
        DIN = D'($urandom);
        PSUM_IN = P'($urandom);
        q.push_back(model(DIN, mw, PSUM_IN, signed_mode));
        last_din = DIN;
        step();
        exp_v = q.pop_front();
        total++;
        if (PSUM_OUT !== exp_v || psum_valid !== 1 || DF_COL !== last_din) begin
          bad++;
          $display("FAIL b2b m=%0d i=%0d got %h want %h", m, i, PSUM_OUT, exp_v);
        end
        last_psum = exp_v;
      end
      din_valid = 0;
    end
  endtask

  task automatic test_hold_and_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (PSUM_OUT !== last_psum || DF_COL !== last_din ||
          psum_valid !== 0 || df_valid !== 0) begin
        bad++;
        $display("FAIL hold c=%0d got %h/%h want %h/%h", i, PSUM_OUT, DF_COL, last_psum, last_din);
      end
    end
    W_IN = 8'd5; w_shift_in = 1; step();
    w_shift_in = 1; swap_in = 1; din_valid = 1; DIN = 9; PSUM_IN = 3;
    rst = 1; step();
    rst = 0; idle();
    total++;
    if ({DF_COL, df_valid, PSUM_OUT, psum_valid, W_OUT,
         w_shift_out, swap_out, shadow_full} !== '0) begin
      bad++;
      $display("FAIL mid_reset got DF=%h PS=%h WO=%h full=%b",
               DF_COL, PSUM_OUT, W_OUT, shadow_full);
    end
    din_valid = 1; DIN = 5; PSUM_IN = 7;
    q.push_back(19'd7);
    step(); din_valid = 0;
    exp_v = q.pop_front();
    total++;
    if (PSUM_OUT !== exp_v) begin
      bad++;
      $display("FAIL post_reset_w got %0d want %0d", PSUM_OUT, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_swap_with_mac();
    test_empty_swap();
    test_shift_swap();
    test_range();
    test_back_to_back();
    test_hold_and_reset();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
